can_frame_receiver: RTL and testbench
=====================================

# can_frame_receiver

Bit-level CAN 2.0A/2.0B frame receiver. It consumes one de-stuffed bus bit per sample strobe and walks a frame-field state machine from SOF through EOF. It extracts identifier, IDE, RTR, DLC and up to 8 data bytes, then pulses a completion flag. It sits between the bit-timing/de-stuffing logic and the controller's receive buffer. It does not check CRC, form or ACK.

## Interface
Parameters: none.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_bit_curr  in  1  current bus bit (0 = dominant)
- sample_point  in  1  one-clk strobe; a bit is consumed on any clk rising edge with sample_point=1
- remove_stuff_bit  in  1  when 1 at a sample edge, the bit is a stuff bit and is discarded (no state/counter change)
- rx_data_array  out  8 x [7:0]  received data bytes, index 0 = first byte
- rx_done_flag  out  1  one-clk pulse at frame completion
- rx_id_std  out  11  base identifier
- rx_id_ext  out  18  extended identifier (valid when rx_ide=1)
- rx_ide  out  1  IDE bit value
- rx_dlc  out  4  DLC field as received
- rx_remote_req  out  1  RTR bit value (1 = remote frame)
- bit_de_stuffing_en  out  1  1 while inside the stuffed region (SOF through last CRC bit)

## Operation
- States: IDLE, ID_STD, SRR_RTR, IDE, ID_EXT, RTR_EXT, R1, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, DONE.
- An accepted bit is a sample edge with remove_stuff_bit=0. Every field below advances only on accepted bits.
- IDLE: recessive bits are ignored. An accepted 0 is SOF: go to ID_STD and clear the bit counter.
- ID_STD: 11 bits, MSB first, shifted into rx_id_std. Then SRR_RTR.
- SRR_RTR: the bit is stored in rx_remote_req. Then IDE.
- IDE: the bit goes to rx_ide. If 0, go to R0. If 1, go to ID_EXT.
- ID_EXT: 18 bits, MSB first, into rx_id_ext. Then RTR_EXT, whose bit overwrites rx_remote_req. Then R1, then R0.
- R1 and R0: the bit is ignored. After R0, go to DLC.
- DLC: 4 bits, MSB first, into rx_dlc.
- Byte count = min(rx_dlc, 8).
- If rx_remote_req=1 or byte count = 0, skip DATA and go to CRC. Otherwise go to DATA.
- DATA: byte count x 8 bits, MSB first. Byte k goes to rx_data_array[k]. Bytes that are not received keep their previous value.
- CRC: 15 bits, counted and discarded.
- CRC_DEL, ACK, ACK_DEL: 1 bit each; the values are ignored.
- EOF: 7 bits; the values are ignored. After the 7th bit, go to DONE.
- DONE: lasts one clk. rx_done_flag=1 for that clk, then go to IDLE. IFS and idle bits are then ignored.
- bit_de_stuffing_en=1 in every state from ID_STD through CRC, and in the SOF-accept cycle. It is 0 in IDLE, CRC_DEL through DONE.
- Output fields update as bits shift in. They stay stable from the end of their field until overwritten by the next frame.

## Timing
- Reset (asynchronous, rst_n=0) forces:
  - state IDLE and all counters 0
  - every output 0, including all 8 data bytes and rx_done_flag
- Reset mid-frame aborts the frame with no done pulse.
- Frame length in accepted bits:
  - standard: 19 + 8*N + 25
  - extended: 39 + 8*N + 25
- rx_done_flag rises on the clk edge after the edge that sampled the 7th EOF bit, and lasts exactly 1 clk.
- A sample edge coinciding with DONE is ignored.
- A sample edge with remove_stuff_bit=1 changes nothing. This holds even outside the stuffed region.
- sample_point held high for several clks consumes one bit per clk. The upstream logic guarantees a 1-clk strobe.

## Test plan
- Standard data frame: SOF, ID=0x7FF, RTR=0, IDE=0, r0=0, DLC=0010, bytes 0xAB then 0xCD, 15 CRC 1s, delimiter 1, ACK 0, ACK-del 1, EOF 7x1 -> one done pulse; rx_id_std=0x7FF, rx_dlc=2, data[0]=0xAB, data[1]=0xCD, rx_ide=0, rx_remote_req=0.
- Extended frame: ID=0x123, SRR=1, IDE=1, ext=0x2ABCD, RTR=0, DLC=1, byte 0x5A -> rx_ide=1, rx_id_std=0x123, rx_id_ext=0x2ABCD, data[0]=0x5A, done pulse.
- Remote frame: standard, RTR=1, DLC=4 -> no data bits consumed, CRC follows DLC directly, rx_remote_req=1, rx_dlc=4, data array unchanged.
- Stuff removal: insert extra bits with remove_stuff_bit=1 inside ID and data -> same decoded values as the unstuffed frame; bit_de_stuffing_en=1 from SOF to last CRC bit, 0 after.
- DLC=9: 64 data bits consumed -> rx_dlc=9, all 8 bytes filled, done pulse after EOF.
- Reset mid-data: assert rst_n=0 during DATA -> all outputs 0, no done pulse; the next full frame decodes correctly.

Source files
------------

// File: rtl/can_frame_receiver.sv
// ---------------------------------------------------------------------------
// can_frame_receiver
//
// Bit-level CAN 2.0A/2.0B frame receiver. Consumes one de-stuffed bus bit per
// sample strobe and walks the frame fields from SOF through EOF, extracting
// identifier, IDE, RTR, DLC and up to eight data bytes, then pulses a
// completion flag for one clock. CRC, form and ACK are not checked.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   rx_bit_curr         current bus bit (0 = dominant)
//   sample_point        one-clk strobe; a bit is consumed on every edge it is high
//   remove_stuff_bit    marks the strobed bit as a stuff bit to be discarded
//   rx_data_array       received data bytes, index 0 = first byte
//   rx_done_flag        one-clk pulse when the frame completes
//   rx_id_std           11-bit base identifier
//   rx_id_ext           18-bit extended identifier (valid when rx_ide = 1)
//   rx_ide              IDE bit value
//   rx_dlc              DLC field as received
//   rx_remote_req       RTR bit value (1 = remote frame)
//   bit_de_stuffing_en  high while inside the stuffed region (SOF..last CRC bit)
// ---------------------------------------------------------------------------
module can_frame_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_bit_curr,
  input  logic        sample_point,
  input  logic        remove_stuff_bit,
  output logic [7:0]  rx_data_array [0:7],
  output logic        rx_done_flag,
  output logic [10:0] rx_id_std,
  output logic [17:0] rx_id_ext,
  output logic        rx_ide,
  output logic [3:0]  rx_dlc,
  output logic        rx_remote_req,
  output logic        bit_de_stuffing_en
);

  typedef enum logic [3:0] {
    IDLE,
    ID_STD,
    SRR_RTR,
    IDE,
    ID_EXT,
    RTR_EXT,
    R1,
    R0,
    DLC,
    DATA,
    CRC,
    CRC_DEL,
    ACK,
    ACK_DEL,
    EOF,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [5:0]  bit_cnt;
  logic        accepted;
  logic [3:0]  byte_cnt;
  logic [6:0]  data_bits;
  logic        data_last;
  logic [3:0]  dlc_full;

  // A strobed bit flagged as stuff is invisible to every field and counter.
  assign accepted  = sample_point & ~remove_stuff_bit;

  // DLC values 9..15 still carry only eight bytes.
  assign byte_cnt  = rx_dlc[3] ? 4'd8 : rx_dlc;
  assign data_bits = {byte_cnt, 3'b000};
  assign data_last = ({1'b0, bit_cnt} == (data_bits - 7'd1));

  // The full DLC is only complete once the bit on the wire is shifted in, so
  // the DATA/CRC decision looks at the shifted value, not the register.
  assign dlc_full  = {rx_dlc[2:0], rx_bit_curr};

  // State register: holds the current frame field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and flag decode. Each field advances only on accepted bits,
  // except DONE which always returns to IDLE after one clock so a strobe
  // landing in DONE is dropped. The de-stuffing enable also covers the cycle
  // in which SOF is being accepted, so the stuffing logic sees SOF as stuffed.
  always_comb begin
    state_next         = state;
    bit_de_stuffing_en = 1'b0;
    rx_done_flag       = 1'b0;
    case (state)
      IDLE: begin
        if (accepted && !rx_bit_curr) begin
          state_next         = ID_STD;
          bit_de_stuffing_en = 1'b1;
        end
      end
      ID_STD: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted && bit_cnt == 6'd10) state_next = SRR_RTR;
      end
      SRR_RTR: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted) state_next = IDE;
      end
      IDE: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted) state_next = rx_bit_curr ? ID_EXT : R0;
      end
      ID_EXT: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted && bit_cnt == 6'd17) state_next = RTR_EXT;
      end
      RTR_EXT: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted) state_next = R1;
      end
      R1: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted) state_next = R0;
      end
      R0: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted) state_next = DLC;
      end
      DLC: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted && bit_cnt == 6'd3) begin
          state_next = (rx_remote_req || dlc_full == 4'd0) ? CRC : DATA;
        end
      end
      DATA: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted && data_last) state_next = CRC;
      end
      CRC: begin
        bit_de_stuffing_en = 1'b1;
        if (accepted && bit_cnt == 6'd14) state_next = CRC_DEL;
      end
      CRC_DEL: begin
        if (accepted) state_next = ACK;
      end
      ACK: begin
        if (accepted) state_next = ACK_DEL;
      end
      ACK_DEL: begin
        if (accepted) state_next = EOF;
      end
      EOF: begin
        if (accepted && bit_cnt == 6'd6) state_next = DONE;
      end
      DONE: begin
        rx_done_flag = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit counter within the current field. It restarts whenever the field
  // changes, so every field counts from zero without per-state bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 6'd0;
    end else if (state_next != state) begin
      bit_cnt <= 6'd0;
    end else if (accepted && state != IDLE) begin
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Field capture. Fields shift MSB first as bits arrive and then hold until
  // the next frame overwrites them; data bytes beyond the received count keep
  // their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        rx_data_array[k] <= 8'h00;
      end
      rx_id_std     <= 11'd0;
      rx_id_ext     <= 18'd0;
      rx_ide        <= 1'b0;
      rx_dlc        <= 4'd0;
      rx_remote_req <= 1'b0;
    end else if (accepted) begin
      case (state)
        ID_STD:  rx_id_std     <= {rx_id_std[9:0], rx_bit_curr};
        SRR_RTR: rx_remote_req <= rx_bit_curr;
        IDE:     rx_ide        <= rx_bit_curr;
        ID_EXT:  rx_id_ext     <= {rx_id_ext[16:0], rx_bit_curr};
        RTR_EXT: rx_remote_req <= rx_bit_curr;
        DLC:     rx_dlc        <= dlc_full;
        DATA: begin
          rx_data_array[bit_cnt[5:3]] <= {rx_data_array[bit_cnt[5:3]][6:0], rx_bit_curr};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_can_frame_receiver
//
// Builds complete CAN frames as bit queues from their field values, plays
// them into the receiver with random strobe gaps and random stuff bits, and
// compares the decoded fields against a field-level reference model.
// ---------------------------------------------------------------------------
module tb_can_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_bit_curr;
  logic        sample_point;
  logic        remove_stuff_bit;
  logic [7:0]  rx_data_array [0:7];
  logic        rx_done_flag;
  logic [10:0] rx_id_std;
  logic [17:0] rx_id_ext;
  logic        rx_ide;
  logic [3:0]  rx_dlc;
  logic        rx_remote_req;
  logic        bit_de_stuffing_en;

  int n_checks   = 0;
  int n_pass     = 0;
  int done_count = 0;

  // Reference model of the receiver outputs, kept at field level.
  logic [7:0]  model_data [0:7];
  logic [10:0] model_id_std;
  logic [17:0] model_id_ext;
  logic        model_ide;
  logic [3:0]  model_dlc;
  logic        model_rtr;

  logic frame_q [$];

  can_frame_receiver dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rx_bit_curr        (rx_bit_curr),
    .sample_point       (sample_point),
    .remove_stuff_bit   (remove_stuff_bit),
    .rx_data_array      (rx_data_array),
    .rx_done_flag       (rx_done_flag),
    .rx_id_std          (rx_id_std),
    .rx_id_ext          (rx_id_ext),
    .rx_ide             (rx_ide),
    .rx_dlc             (rx_dlc),
    .rx_remote_req      (rx_remote_req),
    .bit_de_stuffing_en (bit_de_stuffing_en)
  );

  always #5 clk = ~clk;

  // Count every clock in which the completion flag is seen high.
  always @(negedge clk) begin
    if (rx_done_flag === 1'b1) done_count++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic modelReset();
    for (int k = 0; k < 8; k++) model_data[k] = 8'h00;
    model_id_std = '0;
    model_id_ext = '0;
    model_ide    = 1'b0;
    model_dlc    = '0;
    model_rtr    = 1'b0;
  endtask

  task automatic checkAllOutputs(input string ctx);
    checkOutput({ctx, "_id_std"}, 32'(rx_id_std), 32'(model_id_std));
    checkOutput({ctx, "_id_ext"}, 32'(rx_id_ext), 32'(model_id_ext));
    checkOutput({ctx, "_ide"},    32'(rx_ide),    32'(model_ide));
    checkOutput({ctx, "_dlc"},    32'(rx_dlc),    32'(model_dlc));
    checkOutput({ctx, "_rtr"},    32'(rx_remote_req), 32'(model_rtr));
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s_data%0d", ctx, k), 32'(rx_data_array[k]), 32'(model_data[k]));
    end
  endtask

  // Present one strobed bit; the enable is checked while the bit is on the wire.
  task automatic applyStimulus(input logic b, input logic stuff, input logic exp_en, input int gap);
    @(negedge clk);
    rx_bit_curr      = b;
    sample_point     = 1'b1;
    remove_stuff_bit = stuff;
    #1 checkOutput(stuff ? "stuff_bit_destuff_en" : "destuff_en", 32'(bit_de_stuffing_en), 32'(exp_en));
    @(posedge clk);
    #1;
    sample_point     = 1'b0;
    remove_stuff_bit = 1'b0;
    rx_bit_curr      = 1'b1;
    repeat (gap) @(posedge clk);
  endtask

  task automatic pushField(input logic [31:0] v, input int width);
    for (int i = width - 1; i >= 0; i--) frame_q.push_back(v[i]);
  endtask

  // Build a frame from its fields, play it, and compare against the model.
  // abort_at >= 0 pulls reset just before that frame bit instead of finishing.
  task automatic runFrame(input string name, input logic [10:0] id, input logic ide, input logic srr,
                          input logic [17:0] ext, input logic rtr, input logic [3:0] dlc,
                          input logic [7:0][7:0] data, input logic [14:0] crc,
                          input int stuff_pct, input int abort_at);
    int nbytes;
    int last_crc;
    nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    frame_q.delete();
    frame_q.push_back(1'b0);
    pushField(32'(id), 11);
    if (ide) begin
      pushField(32'(srr), 1);
      pushField(32'd1, 1);
      pushField(32'(ext), 18);
      pushField(32'(rtr), 1);
      pushField($urandom_range(0, 1), 1);
      pushField($urandom_range(0, 1), 1);
    end else begin
      pushField(32'(rtr), 1);
      pushField(32'd0, 1);
      pushField($urandom_range(0, 1), 1);
    end
    pushField(32'(dlc), 4);
    for (int k = 0; k < nbytes; k++) pushField(32'(data[k]), 8);
    pushField(32'(crc), 15);
    pushField(32'd1, 1);
    pushField(32'd0, 1);
    pushField(32'd1, 1);
    pushField(32'h7F, 7);
    last_crc   = frame_q.size() - 11;
    done_count = 0;

    // Idle traffic before SOF: recessive bits and a dominant stuff-flagged bit
    // must not start a frame.
    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    if (stuff_pct > 0) applyStimulus(1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == abort_at) begin
        @(negedge clk);
        rst_n        = 1'b0;
        sample_point = 1'b0;
        #1;
        modelReset();
        checkAllOutputs({name, "_abort"});
        checkOutput({name, "_abort_destuff_en"}, 32'(bit_de_stuffing_en), 32'd0);
        checkOutput({name, "_abort_done_flag"}, 32'(rx_done_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput({name, "_abort_done_count"}, 32'(done_count), 32'd0);
        return;
      end
      if (i > 0 && i <= last_crc && $urandom_range(0, 99) < stuff_pct) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, $urandom_range(0, 2));
      end
      if (i == frame_q.size() - 1) begin
        // Last EOF bit: the flag must be up right after this edge, and a
        // dominant strobe held into the DONE clock must be dropped.
        @(negedge clk);
        rx_bit_curr      = frame_q[i];
        sample_point     = 1'b1;
        remove_stuff_bit = 1'b0;
        #1 checkOutput({name, "_eof_destuff_en"}, 32'(bit_de_stuffing_en), 32'd0);
        checkOutput({name, "_done_early"}, 32'(rx_done_flag), 32'd0);
        @(posedge clk);
        #1 checkOutput({name, "_done_rise"}, 32'(rx_done_flag), 32'd1);
        rx_bit_curr = 1'b0;
        @(posedge clk);
        #1 checkOutput({name, "_done_fall"}, 32'(rx_done_flag), 32'd0);
        sample_point = 1'b0;
        rx_bit_curr  = 1'b1;
        #1 checkOutput({name, "_post_done_destuff_en"}, 32'(bit_de_stuffing_en), 32'd0);
      end else begin
        applyStimulus(frame_q[i], 1'b0, 1'(i <= last_crc), $urandom_range(0, 2));
      end
    end

    model_id_std = id;
    model_ide    = ide;
    if (ide) model_id_ext = ext;
    model_rtr    = rtr;
    model_dlc    = dlc;
    for (int k = 0; k < nbytes; k++) model_data[k] = data[k];

    repeat (3) @(negedge clk);
    checkOutput({name, "_done_count"}, 32'(done_count), 32'd1);
    checkAllOutputs(name);
  endtask

  initial begin
    logic [7:0][7:0] d;
    rst_n            = 1'b0;
    rx_bit_curr      = 1'b1;
    sample_point     = 1'b0;
    remove_stuff_bit = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkAllOutputs("reset");
    checkOutput("reset_done_flag", 32'(rx_done_flag), 32'd0);
    checkOutput("reset_destuff_en", 32'(bit_de_stuffing_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released, starting directed frames");

    d = '0; d[0] = 8'hAB; d[1] = 8'hCD;
    runFrame("std", 11'h7FF, 1'b0, 1'b0, 18'h0, 1'b0, 4'd2, d, 15'h7FFF, 0, -1);

    d = '0; d[0] = 8'h5A;
    runFrame("ext", 11'h123, 1'b1, 1'b1, 18'h2ABCD, 1'b0, 4'd1, d, 15'h7FFF, 0, -1);

    d = {8{8'hEE}};
    runFrame("remote", 11'h0F0, 1'b0, 1'b0, 18'h0, 1'b1, 4'd4, d, 15'h7FFF, 0, -1);

    d = '0; d[0] = 8'h3C; d[1] = 8'h96;
    runFrame("stuffed", 11'h555, 1'b0, 1'b0, 18'h0, 1'b0, 4'd2, d, 15'h7FFF, 35, -1);

    d = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    runFrame("dlc9", 11'h001, 1'b0, 1'b0, 18'h0, 1'b0, 4'd9, d, 15'h1234, 0, -1);

    d = {8{8'hA5}};
    runFrame("abort", 11'h2AA, 1'b0, 1'b0, 18'h0, 1'b0, 4'd8, d, 15'h7FFF, 0, 19 + 13);

    d = '0; d[0] = 8'hC3; d[1] = 8'h0F; d[2] = 8'hF0;
    runFrame("after_abort", 11'h4D2, 1'b0, 1'b0, 18'h0, 1'b0, 4'd3, d, 15'h0ACE, 10, -1);

    $display("[TB] starting random frames");
    for (int n = 0; n < 24; n++) begin
      d = {$urandom, $urandom};
      runFrame($sformatf("rand%0d", n), 11'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 3) == 0),
               4'($urandom), d, 15'($urandom), $urandom_range(0, 25), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
